corr_peak_detector: RTL and testbench

Downstream stage of the correlator. Consumes the correlator's 4-bit match-count stream, one sample per `corr_valid`, and splits it into fixed windows. For each window it finds the maximum correlation and its position. If that maximum reaches a threshold, it reports a detection (value, index) to the framing logic over a valid/ready handshake, then applies a hold-off so one sync word is not reported twice.

---
 rtl/corr_peak_detector_pkg.sv | 19 +
 rtl/corr_peak_detector_if.sv | 25 ++
 rtl/corr_peak_detector_peak_tracker.sv | 38 +++
 rtl/corr_peak_detector.sv | 116 +++++++++++
 tb/tb_corr_peak_detector.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/corr_peak_detector_pkg.sv
// Shared definitions for the correlator back end: default widths, the
// detector state encoding and the (value, index) detection report.
package corr_peak_detector_pkg;

    localparam int CORR_W_DFLT = 4;
    localparam int WINDOW_DFLT = 16;
    localparam int IDX_W_DFLT  = $clog2(WINDOW_DFLT);

    typedef enum logic {
        ST_SCAN    = 1'b0,
        ST_HOLDOFF = 1'b1
    } state_t;

    typedef struct packed {
        logic [CORR_W_DFLT-1:0] value;
        logic [IDX_W_DFLT-1:0]  index;
    } report_t;

endpackage

// File: rtl/corr_peak_detector_if.sv
// Correlation sample stream in, detection report out over valid/ready.
// master = producer of samples and consumer of reports; slave = the detector.
interface corr_peak_detector_if #(
    parameter int CORR_W = 4,
    parameter int IDX_W  = 4
) ();

    logic [CORR_W-1:0] corr_in;
    logic              corr_valid;
    logic [CORR_W-1:0] peak_value;
    logic [IDX_W-1:0]  peak_index;
    logic              peak_valid;
    logic              peak_ready;

    modport master (
        output corr_in, corr_valid, peak_ready,
        input  peak_value, peak_index, peak_valid
    );

    modport slave (
        input  corr_in, corr_valid, peak_ready,
        output peak_value, peak_index, peak_valid
    );

endinterface

// File: rtl/corr_peak_detector_peak_tracker.sv
// Running max/argmax over a window. peak_val/peak_idx already include the
// current sample, so the caller can read the final peak on the window's last sample.
module peak_tracker #(
    parameter int VAL_W = 4,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic             start,
    input  logic [VAL_W-1:0] sample,
    input  logic [IDX_W-1:0] sample_idx,
    output logic [VAL_W-1:0] peak_val,
    output logic [IDX_W-1:0] peak_idx
);

    logic [VAL_W-1:0] max_val;
    logic [IDX_W-1:0] max_idx;
    logic             take;

    // Strict '>' keeps the earliest index on ties; start discards the old window.
    assign take     = start || (sample > max_val);
    assign peak_val = take ? sample     : max_val;
    assign peak_idx = take ? sample_idx : max_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (sample_valid && take) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            max_val <= sample;
            max_idx <= sample_idx;
        end
    end

endmodule

// File: rtl/corr_peak_detector.sv
// Windowed peak detector: reports the per-window max (value, index) when it
// reaches THRESHOLD, then ignores HOLDOFF valid samples.
module corr_peak_detector
    import corr_peak_detector_pkg::*;
#(
    parameter int CORR_W    = CORR_W_DFLT,
    parameter int WINDOW    = WINDOW_DFLT,
    parameter int THRESHOLD = 6,
    parameter int HOLDOFF   = 4,
    parameter int IDX_W     = $clog2(WINDOW)
) (
    input  logic                 clk,
    input  logic                 reset,
    corr_peak_detector_if.slave  bus,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                HOLD_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CORR_W-1:0] THR       = CORR_W'(THRESHOLD);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WINDOW - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam bit                USE_HOLD  = (HOLDOFF > 0);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  sample_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              scan_valid;
    logic              window_end;
    logic              load;
    logic [CORR_W-1:0] final_val;
    logic [IDX_W-1:0]  final_idx;
    logic [CORR_W-1:0] peak_value_q;
    logic [IDX_W-1:0]  peak_index_q;
    logic              peak_valid_q;

    assign scan_valid = bus.corr_valid && (state == ST_SCAN);

    peak_tracker #(
        .VAL_W (CORR_W),
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (scan_valid),
        .start        (sample_idx == '0),
        .sample       (bus.corr_in),
        .sample_idx   (sample_idx),
        .peak_val     (final_val),
        .peak_idx     (final_idx)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt  = state;
        window_end = 1'b0;
        load       = 1'b0;
        case (state)
            ST_SCAN: begin
                if (bus.corr_valid && (sample_idx == LAST_IDX)) begin
                    window_end = 1'b1;
                    load       = (final_val >= THR);
                    if (load && USE_HOLD) begin
                        state_nxt = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (bus.corr_valid && (hold_cnt == HOLD_W'(1))) begin
                    state_nxt = ST_SCAN;
                end
            end
            default: state_nxt = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_SCAN;
            sample_idx   <= '0;
            hold_cnt     <= '0;
            peak_value_q <= '0;
            peak_index_q <= '0;
            peak_valid_q <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (scan_valid) begin
                sample_idx <= window_end ? '0 : sample_idx + IDX_W'(1);
            end
            if (load && USE_HOLD) begin
                hold_cnt <= HOLD_LOAD;
            end else if ((state == ST_HOLDOFF) && bus.corr_valid) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            // A new load wins over a completing transfer; only an unaccepted report counts as overrun.
            if (load) begin
                peak_value_q <= final_val;
                peak_index_q <= final_idx;
                peak_valid_q <= 1'b1;
                if (peak_valid_q && !bus.peak_ready) begin
                    overrun <= 1'b1;
                end
            end else if (peak_valid_q && bus.peak_ready) begin
                peak_valid_q <= 1'b0;
            end
        end
    end

    assign bus.peak_value = peak_value_q;
    assign bus.peak_index = peak_index_q;
    assign bus.peak_valid = peak_valid_q;
    assign busy           = (state == ST_HOLDOFF);

endmodule

// File: tb/tb_corr_peak_detector.sv
// Directed bench: dut_a uses HOLDOFF=4, dut_b uses HOLDOFF=0 for backpressure
// and the table of window vectors.
module tb_corr_peak_detector;
    import corr_peak_detector_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic overrun_a, busy_a, overrun_b, busy_b;

    always #5 clk = ~clk;

    corr_peak_detector_if #(.CORR_W(4), .IDX_W(4)) bus_a ();
    corr_peak_detector_if #(.CORR_W(4), .IDX_W(4)) bus_b ();

    corr_peak_detector #(
        .CORR_W(4), .WINDOW(16), .THRESHOLD(6), .HOLDOFF(4)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .overrun(overrun_a), .busy(busy_a)
    );

    corr_peak_detector #(
        .CORR_W(4), .WINDOW(16), .THRESHOLD(6), .HOLDOFF(0)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .overrun(overrun_b), .busy(busy_b)
    );

    typedef struct {
        logic [3:0] fill;
        int         i1;
        logic [3:0] v1;
        int         i2;
        logic [3:0] v2;
        bit         exp_valid;
        report_t    exp;
    } vec_t;

    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [3:0] d);
        if (sel) begin
            bus_b.corr_valid = v;
            bus_b.corr_in    = d;
        end else begin
            bus_a.corr_valid = v;
            bus_a.corr_in    = d;
        end
    endtask

    task automatic pulse_ready(input bit sel);
        if (sel) bus_b.peak_ready = 1'b1; else bus_a.peak_ready = 1'b1;
        tick();
        if (sel) bus_b.peak_ready = 1'b0; else bus_a.peak_ready = 1'b0;
    endtask

    function automatic logic [63:0] mk(input logic [3:0] fill, input int i1, input logic [3:0] v1,
                                       input int i2, input logic [3:0] v2);
        logic [63:0] w;
        for (int i = 0; i < 16; i++) w[4*i +: 4] = fill;
        w[4*i1 +: 4] = v1;
        w[4*i2 +: 4] = v2;
        return w;
    endfunction

    task automatic feed(input bit sel, input logic [63:0] w, input int first, input int last,
                        input bit gaps);
        int g;
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    set_in(sel, 1'b0, 4'd0);
                    tick();
                end
            end
            set_in(sel, 1'b1, w[4*i +: 4]);
            tick();
        end
        set_in(sel, 1'b0, 4'd0);
    endtask

    task automatic check_a(input string name, input logic [3:0] value, input logic [3:0] index);
        check({name, "_valid"}, bus_a.peak_valid, 1);
        check({name, "_value"}, bus_a.peak_value, value);
        check({name, "_index"}, bus_a.peak_index, index);
    endtask

    task automatic check_b(input string name, input logic [3:0] value, input logic [3:0] index);
        check({name, "_valid"}, bus_b.peak_valid, 1);
        check({name, "_value"}, bus_b.peak_value, value);
        check({name, "_index"}, bus_b.peak_index, index);
    endtask

    initial begin
        logic [63:0] w;

        vecs[0] = '{4'd3, 2,  4'd7,  2,  4'd7,  1'b1, '{4'd7,  4'd2}};
        vecs[1] = '{4'd1, 3,  4'd8,  9,  4'd8,  1'b1, '{4'd8,  4'd3}};
        vecs[2] = '{4'd2, 5,  4'd5,  5,  4'd5,  1'b0, '{4'd0,  4'd0}};
        vecs[3] = '{4'd0, 15, 4'd6,  15, 4'd6,  1'b1, '{4'd6,  4'd15}};
        vecs[4] = '{4'd6, 0,  4'd6,  0,  4'd6,  1'b1, '{4'd6,  4'd0}};
        vecs[5] = '{4'd4, 0,  4'd15, 15, 4'd15, 1'b1, '{4'd15, 4'd0}};
        vecs[6] = '{4'd5, 7,  4'd5,  7,  4'd5,  1'b0, '{4'd0,  4'd0}};
        vecs[7] = '{4'd0, 10, 4'd9,  11, 4'd12, 1'b1, '{4'd12, 4'd11}};

        // Reset held for two cycles while dut_a sees traffic.
        reset = 1'b1;
        bus_a.corr_valid = 1'b1; bus_a.corr_in = 4'd9; bus_a.peak_ready = 1'b0;
        bus_b.corr_valid = 1'b0; bus_b.corr_in = 4'd0; bus_b.peak_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("rst_value", bus_a.peak_value, 0);
        check("rst_index", bus_a.peak_index, 0);
        check("rst_valid", bus_a.peak_valid, 0);
        check("rst_overrun", overrun_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_valid", bus_b.peak_valid, 0);
        check("rst_b_overrun", overrun_b, 0);
        reset = 1'b0;
        set_in(0, 1'b0, 4'd0);

        // Single peak, latency and hold while not ready.
        w = mk(4'd3, 2, 4'd7, 2, 4'd7);
        feed(0, w, 0, 14, 0);
        check("single_pre_last_valid", bus_a.peak_valid, 0);
        feed(0, w, 15, 15, 0);
        check_a("single", 4'd7, 4'd2);
        check("single_busy", busy_a, 1);
        tick();
        tick();
        check("single_hold_valid", bus_a.peak_valid, 1);
        check("single_hold_value", bus_a.peak_value, 7);
        pulse_ready(0);
        check("single_accepted", bus_a.peak_valid, 0);

        // Hold-off: four samples of 8 are discarded.
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b1, 4'd8);
            tick();
            check($sformatf("holdoff_busy%0d", i), busy_a, (i < 3) ? 1 : 0);
        end
        set_in(0, 1'b0, 4'd0);
        check("holdoff_no_report", bus_a.peak_valid, 0);
        feed(0, mk(4'd1, 0, 4'd9, 0, 4'd9), 0, 15, 0);
        check_a("after_holdoff", 4'd9, 4'd0);
        pulse_ready(0);
        feed(0, mk(4'd0, 0, 4'd0, 0, 4'd0), 0, 3, 0);
        check("drain1_busy", busy_a, 0);

        // Same window as the single-peak case, with valid gaps.
        feed(0, mk(4'd3, 2, 4'd7, 2, 4'd7), 0, 15, 1);
        check_a("gaps", 4'd7, 4'd2);
        pulse_ready(0);
        feed(0, mk(4'd0, 0, 4'd0, 0, 4'd0), 0, 3, 1);
        check("drain2_busy", busy_a, 0);

        // Mid-window reset at sample 10 discards the partial window.
        feed(0, mk(4'd0, 5, 4'd15, 5, 4'd15), 0, 9, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", bus_a.peak_valid, 0);
        check("midrst_busy", busy_a, 0);
        feed(0, mk(4'd1, 3, 4'd7, 3, 4'd7), 0, 15, 0);
        check_a("after_midrst", 4'd7, 4'd3);
        check("a_no_overrun", overrun_a, 0);
        pulse_ready(0);

        // Backpressure on dut_b (no hold-off).
        feed(1, mk(4'd0, 1, 4'd7, 1, 4'd7), 0, 15, 0);
        check_b("bp_first", 4'd7, 4'd1);
        check("bp_first_overrun", overrun_b, 0);
        check("b_busy", busy_b, 0);
        feed(1, mk(4'd0, 4, 4'd8, 4, 4'd8), 0, 15, 0);
        check_b("bp_second", 4'd8, 4'd4);
        check("bp_overrun", overrun_b, 1);
        pulse_ready(1);
        check("bp_drained", bus_b.peak_valid, 0);
        check("bp_overrun_sticky", overrun_b, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("bp_overrun_cleared", overrun_b, 0);

        // Handshake and a new load in the same cycle: no overrun.
        feed(1, mk(4'd0, 1, 4'd7, 1, 4'd7), 0, 15, 0);
        w = mk(4'd0, 4, 4'd8, 4, 4'd8);
        feed(1, w, 0, 14, 0);
        bus_b.peak_ready = 1'b1;
        feed(1, w, 15, 15, 0);
        bus_b.peak_ready = 1'b0;
        check_b("same_cycle", 4'd8, 4'd4);
        check("same_cycle_overrun", overrun_b, 0);
        pulse_ready(1);

        // Table-driven windows on dut_b.
        for (int v = 0; v < 8; v++) begin
            feed(1, mk(vecs[v].fill, vecs[v].i1, vecs[v].v1, vecs[v].i2, vecs[v].v2), 0, 15, 0);
            check($sformatf("vec%0d_valid", v), bus_b.peak_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_value", v), bus_b.peak_value, vecs[v].exp.value);
                check($sformatf("vec%0d_index", v), bus_b.peak_index, vecs[v].exp.index);
            end
            pulse_ready(1);
            check($sformatf("vec%0d_cleared", v), bus_b.peak_valid, 0);
        end
        check("b_final_overrun", overrun_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
